// File: rtl/pattern_tx_pkg.sv
// pattern_tx_pkg -- shared types and defaults for the pattern_tx serializer.
//   PTX_WIDTH : default maximum word width in bits
//   PTX_LEN_W : default width of load_len, clog2(PTX_WIDTH+1)
//   state_e   : serializer FSM states; PARITY exists only when
//               PATTERN_TX_PARITY_EN is defined.
package pattern_tx_pkg;

    localparam int PTX_WIDTH = 16;
    localparam int PTX_LEN_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef PATTERN_TX_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_e;

endpackage

// File: rtl/pattern_tx_if.sv
// pattern_tx_if -- load handshake plus serial output bundle of pattern_tx.
//   load_valid/load_ready/load_data/load_len : parallel word handshake
//   dout/dout_valid/dout_last                : serial bit stream
//   modport slave  : the serializer side
//   modport master : the word producer / stream consumer side
interface pattern_tx_if
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = PTX_WIDTH,
    parameter int LEN_W = PTX_LEN_W
) ();

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic             dout;
    logic             dout_valid;
    logic             dout_last;

    modport slave (
        input  load_valid, load_data, load_len,
        output load_ready, dout, dout_valid, dout_last
    );

    modport master (
        output load_valid, load_data, load_len,
        input  load_ready, dout, dout_valid, dout_last
    );

endinterface

// File: rtl/ptx_shreg.sv
// ptx_shreg -- WIDTH-bit load / shift-left register with running parity.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture din; din[WIDTH-1] is taken as the bit now being sent
//   shift    : advance one bit
//   din      : parallel word
//   ser_o    : serial MSB output = next bit to be sent
//   par_o    : XOR of every bit sent so far in this word (even parity)
// The register holds the word pre-shifted by one, because the top already
// drives the first bit straight from din on the load edge.
module ptx_shreg
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = PTX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             ser_o,
    output logic             par_o
);

    logic [WIDTH-1:0] word_q, word_d;
    logic             par_q, par_d;

    always_comb begin
        word_d = word_q;
        par_d  = par_q;
        if (load) begin
            word_d = {din[WIDTH-2:0], 1'b0};
            par_d  = din[WIDTH-1];
        end else if (shift) begin
            word_d = {word_q[WIDTH-2:0], 1'b0};
            par_d  = par_q ^ word_q[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            par_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            par_q  <= par_d;
        end
    end

    assign ser_o = word_q[WIDTH-1];
    assign par_o = par_q;

endmodule

// File: rtl/pattern_tx.sv
// pattern_tx -- parallel-to-serial pattern transmitter, MSB first.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pattern_tx_if.slave (load handshake in, serial stream out)
// A word of effective length N (N = WIDTH when load_len is 0 or > WIDTH)
// is sent on N consecutive cycles starting the cycle after the transfer.
// load_ready is high in IDLE and on the last-bit cycle, so words chain
// back to back. All outputs come straight from flops.
// Optional: define PATTERN_TX_PARITY_EN to append an even-parity bit
// (state PARITY) that carries dout_last instead of the last data bit.
// WIDTH must be at least 2.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = PTX_WIDTH,
    parameter int LEN_W = PTX_LEN_W
) (
    input  logic         clk,
    input  logic         rst,
    pattern_tx_if.slave  bus
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;     // data bits still to send after the current one
    logic             dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             last_q, last_d;
    logic             rdy_q, rdy_d;

    logic             xfer;
    logic [LEN_W-1:0] eff_len;
    logic             sh_load, sh_shift;
    logic             ser, par;

    ptx_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (bus.load_data),
        .ser_o (ser),
        .par_o (par)
    );

`ifndef PATTERN_TX_PARITY_EN
    logic unused_par;
    assign unused_par = par;
`endif

    assign xfer    = bus.load_valid && rdy_q;
    assign eff_len = (bus.load_len == '0 || int'(bus.load_len) > WIDTH)
                   ? LEN_W'(WIDTH) : bus.load_len;

    always_comb begin
        state_d  = IDLE;
        cnt_d    = cnt_q;
        dout_d   = 1'b0;
        vld_d    = 1'b0;
        last_d   = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        if (xfer) begin
            // Only possible in IDLE or on a last-bit cycle: start new word.
            state_d = SHIFT;
            cnt_d   = eff_len - LEN_W'(1);
            dout_d  = bus.load_data[WIDTH-1];
            vld_d   = 1'b1;
            sh_load = 1'b1;
`ifndef PATTERN_TX_PARITY_EN
            last_d  = (eff_len == LEN_W'(1));
`endif
        end else if (state_q == SHIFT && cnt_q != '0) begin
            state_d  = SHIFT;
            cnt_d    = cnt_q - LEN_W'(1);
            dout_d   = ser;
            vld_d    = 1'b1;
            sh_shift = 1'b1;
`ifndef PATTERN_TX_PARITY_EN
            last_d   = (cnt_q == LEN_W'(1));
`endif
        end
`ifdef PATTERN_TX_PARITY_EN
        else if (state_q == SHIFT) begin
            // Last data bit is on dout now; par already includes it.
            state_d = PARITY;
            dout_d  = par;
            vld_d   = 1'b1;
            last_d  = 1'b1;
        end
`endif
        rdy_d = (state_d == IDLE) || last_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = vld_q;
    assign bus.dout_last  = last_q;
    assign bus.load_ready = rdy_q;

endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx -- self-checking bench for pattern_tx.
// A bit-queue reference model: each accepted word is expanded into the
// list of bits it must produce; every cycle the head of the list is what
// dout must show, and an empty list means idle.
module tb_pattern_tx;

    localparam int W  = 16;
    localparam int LW = 5;
`ifdef PATTERN_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pattern_tx_if #(.WIDTH(W), .LEN_W(LW)) bus ();

    pattern_tx #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mdl_q[$];
    bit          mdl_rst = 1'b1;
    bit          exp_rdy;
    int          n_vld;
    logic [31:0] obs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff_len(input logic [LW-1:0] l);
        return (l == 0 || int'(l) > W) ? W : int'(l);
    endfunction

    task automatic push_word(input logic [W-1:0] d, input logic [LW-1:0] l);
        bit p = 1'b0;
        for (int i = 0; i < eff_len(l); i++) begin
            mdl_q.push_back(d[W-1-i]);
            p ^= d[W-1-i];
        end
        if (PAR != 0) mdl_q.push_back(p);
    endtask

    // One clock: check this cycle's outputs, then drive inputs for the next edge.
    task automatic cyc(input bit r, input bit v, input logic [W-1:0] d,
                       input logic [LW-1:0] l, output bit xf);
        bit e_dout, e_vld, e_last;
        @(negedge clk);
        e_dout = 1'b0; e_vld = 1'b0; e_last = 1'b0;
        if (mdl_rst) begin
            mdl_q.delete();
            exp_rdy = 1'b0;
        end else if (mdl_q.size() > 0) begin
            e_dout  = mdl_q.pop_front();
            e_vld   = 1'b1;
            e_last  = (mdl_q.size() == 0);
            exp_rdy = e_last;
        end else begin
            exp_rdy = 1'b1;
        end
        chk("dout",       32'(bus.dout),       32'(e_dout));
        chk("dout_valid", 32'(bus.dout_valid), 32'(e_vld));
        chk("dout_last",  32'(bus.dout_last),  32'(e_last));
        chk("load_ready", 32'(bus.load_ready), 32'(exp_rdy));
        if (bus.dout_valid === 1'b1) begin
            n_vld++;
            obs = {obs[30:0], bus.dout};
        end
        rst            = r;
        bus.load_valid = v;
        bus.load_data  = d;
        bus.load_len   = l;
        xf      = !r && v && exp_rdy;
        mdl_rst = r;
        if (xf) push_word(d, l);
    endtask

    task automatic send(input logic [W-1:0] d, input logic [LW-1:0] l);
        bit xf = 1'b0;
        int k  = 0;
        while (!xf && k < 50) begin
            cyc(1'b0, 1'b1, d, l, xf);
            k++;
        end
        if (!xf) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Idle cycles with junk on data/len, which must be ignored.
    task automatic idle(input int n);
        bit xf;
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, W'($urandom), LW'($urandom), xf);
    endtask

    initial begin
        bit xf;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_len   = '0;

        // Reset cycle (checked: all zero), then release.
        cyc(1'b0, 1'b0, '0, '0, xf);
        idle(1);

        // Full-width word, len 0.
        obs = '0; n_vld = 0;
        send(16'b0100_0110_0101_0101, 5'd0);
        idle(18);
        chk("w4655_bits", obs, (PAR != 0) ? {15'd0, 16'h4655, 1'b1} : 32'h4655);
        chk("w4655_cnt",  32'(n_vld), 32'(16 + PAR));

        // Short word.
        obs = '0;
        send(16'hA000, 5'd4);
        idle(6);
        chk("a000_bits", obs, (PAR != 0) ? 32'b10100 : 32'b1010);

        // Back to back with load_valid held.
        obs = '0;
        send(16'hFFFF, 5'd2);
        send(16'h0000, 5'd3);
        idle(6);
        chk("b2b_bits", obs, (PAR != 0) ? 32'b1100000 : 32'b11000);

        // Reset on 5th bit of a 16-bit word.
        obs = '0; n_vld = 0;
        send(16'hBEEF, 5'd16);
        idle(4);
        cyc(1'b1, 1'b0, '0, '0, xf);
        idle(4);
        chk("rst_mid_cnt", 32'(n_vld), 32'd5);

        // Oversized length.
        n_vld = 0;
        send(W'($urandom), 5'd20);
        idle(22);
        chk("len20_cnt", 32'(n_vld), 32'(16 + PAR));

        // Random traffic including occasional reset.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)),
                W'($urandom), LW'($urandom_range(0, 31)), xf);
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter WIDTH, default 16, maximum word width in bits.
REQ-002 Parameter LEN_W, default 5, width of load_len; SHALL equal clog2(WIDTH+1).
REQ-003 clk  input  1  rising-edge clock; sole clock of the block.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load_valid  input  1  parallel word offered.
REQ-006 load_ready  output  1  block accepts a word this cycle.
REQ-007 load_data  input  WIDTH  word to serialize, MSB sent first.
REQ-008 load_len  input  LEN_W  number of bits to send, taken from the MSB end.
REQ-009 dout  output  1  serial data bit, the stream a sequence detector's din consumes.
REQ-010 dout_valid  output  1  dout carries a data or parity bit this cycle.
REQ-011 dout_last  output  1  final bit of the current word is on dout this cycle.

Function
REQ-012 States SHALL be IDLE and SHIFT, plus PARITY when the parity feature is compiled in.
REQ-013 Transfer SHALL occur on a rising edge where load_valid && load_ready; load_data and the effective length are captured at that edge.
REQ-014 Effective length SHALL be WIDTH when load_len is 0 or greater than WIDTH; otherwise it is load_len.
REQ-015 The first bit (load_data[WIDTH-1]) SHALL appear on dout in the cycle after the transfer edge; latency is 1 cycle.
REQ-016 In SHIFT, one bit SHALL be sent per cycle, MSB first, with dout_valid=1, for exactly the effective length.
REQ-017 dout_last SHALL be 1 only on the final bit of a word: the last data bit, or the parity bit when parity is enabled.
REQ-018 load_ready SHALL be 1 in IDLE and in the dout_last cycle, and 0 otherwise.
REQ-019 A transfer in the dout_last cycle SHALL start the new word's first bit in the next cycle, with no idle gap.
REQ-020 With no transfer in the dout_last cycle, the next state SHALL be IDLE.
REQ-021 In IDLE, dout, dout_valid and dout_last SHALL all be 0.
REQ-022 load_data and load_len SHALL be ignored when no transfer occurs; changes during SHIFT SHALL have no effect.
REQ-023 All outputs SHALL be registered, and no output SHALL depend combinationally on inputs.

Reset
REQ-024 While rst=1 at an edge: state is IDLE, and dout, dout_valid, dout_last, load_ready and the bit counter are all 0.
REQ-025 load_ready SHALL rise in the first cycle after rst is deasserted.
REQ-026 Reset mid-word SHALL abort the word with no dout_last, and no remaining bits SHALL be sent afterwards.

Configuration
REQ-027 Macro PATTERN_TX_PARITY_EN: when defined, one even-parity bit (XOR of the bits sent) SHALL follow the data bits in state PARITY, with dout_valid=1 and dout_last=1.
REQ-028 Without PATTERN_TX_PARITY_EN, the PARITY state and its logic are absent, and dout_last marks the last data bit.

Structure
REQ-029 Package pattern_tx_pkg SHALL hold the state enum type and the default WIDTH/LEN_W constants.
REQ-030 One sub-module, ptx_shreg, SHALL be used: a WIDTH-bit load/shift-left register with a serial MSB output and a running parity accumulator.
REQ-031 The FSM, bit counter and handshake SHALL reside in pattern_tx.

Verification
REQ-032 Reset for 1 cycle, then load 16'b0100_0110_0101_0101 with len 0 -> dout = 0,1,0,0,0,1,1,0,0,1,0,1,0,1,0,1 on 16 consecutive cycles; dout_last on the 16th.
REQ-033 Load 16'hA000 with len 4 -> dout = 1,0,1,0; dout_last on the 4th; IDLE next cycle with dout_valid=0.
REQ-034 Back-to-back: hold load_valid=1, 16'hFFFF len 2 then 16'h0000 len 3 -> dout = 1,1,0,0,0 contiguously; load_ready high only in the last-bit cycles.
REQ-035 Assert rst on the 5th bit of a 16-bit word -> next cycle dout_valid=0, dout_last never pulses, and load_ready=1 one cycle after rst falls.
REQ-036 With PATTERN_TX_PARITY_EN, 16'h4655 len 16 -> 16 data bits, then a parity bit of 1 with dout_last=1 (17 valid cycles).
REQ-037 load_len=20 with WIDTH=16 -> exactly 16 bits are sent.
